// File: rtl/mac_responder_pkg.sv
// ----------------------------------------------------------------------------
// mac_responder_pkg
// Shared definitions for the mac_responder block:
//   state_t        - responder FSM states (IDLE, RUN)
//   DEFAULT_WIDTH  - default operand / accumulator / return width in bits
// ----------------------------------------------------------------------------
package mac_responder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mac_sat_add.sv
// ----------------------------------------------------------------------------
// mac_sat_add
// Combinational WIDTH-bit adder with carry-out and optional saturation.
//
// Build option:
//   MAC_SATURATE_EN  defined   : on carry-out the sum clamps to 2^WIDTH-1
//                    undefined : the sum wraps modulo 2^WIDTH
//
// Ports:
//   i_a, i_b  [WIDTH-1:0]  addends (unsigned)
//   o_sum     [WIDTH-1:0]  sum (wrapped or clamped)
//   o_carry                carry-out of the raw addition
// ----------------------------------------------------------------------------
module mac_sat_add
  import mac_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // One extra bit holds the carry of the unsigned addition.
  logic [WIDTH:0] w_raw;

  assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_raw[WIDTH];

`ifdef MAC_SATURATE_EN
  // Once the accumulator reaches all-ones, every further non-zero addend
  // carries again, so the clamp holds for the remaining iterations.
  assign o_sum = w_raw[WIDTH] ? {WIDTH{1'b1}} : w_raw[WIDTH-1:0];
`else
  assign o_sum = w_raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_responder.sv
// ----------------------------------------------------------------------------
// mac_responder
// Responder side of a req/busy/return method handshake. A call computes
// mac_num * mac_y by repeated addition, one addition per clock.
//
// Build option: MAC_SATURATE_EN (see mac_sat_add) selects clamping instead
// of wrapping on accumulator overflow; the overflow flag is set either way.
//
// Ports:
//   clk                     clock, rising-edge active
//   reset                   asynchronous, active-low reset
//   mac_num    [WIDTH-1:0]  iteration count argument (unsigned)
//   mac_y      [WIDTH-1:0]  addend argument (unsigned)
//   mac_req                 call request (level)
//   mac_busy                call in progress (registered)
//   mac_return [WIDTH-1:0]  result of the last completed call (registered)
//   mac_ovf                 last completed call overflowed (registered)
//
// Timing: busy rises on the accepting edge and stays high for mac_num+1
// cycles; results update on the edge busy falls and hold until the next
// completion. A request held high restarts on the following edge.
// ----------------------------------------------------------------------------
module mac_responder
  import mac_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mac_num,
  input  logic [WIDTH-1:0] mac_y,
  input  logic             mac_req,
  output logic             mac_busy,
  output logic [WIDTH-1:0] mac_return,
  output logic             mac_ovf
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic             r_flag;
  logic             r_busy;
  logic [WIDTH-1:0] r_return;
  logic             r_ovf;

  logic             w_accept;
  logic             w_step;
  logic             w_done;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  mac_sat_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .i_a     (r_acc),
    .i_b     (r_y),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mac_req) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // mac_req and the arguments are deliberately not looked at here.
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_return <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= mac_num;
        r_y    <= mac_y;
        r_acc  <= '0;
        r_flag <= 1'b0;
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_acc  <= w_sum;
        r_cnt  <= r_cnt - WIDTH'(1);
        r_flag <= r_flag | w_carry;
      end
      if (w_done) begin
        r_return <= r_acc;
        r_ovf    <= r_flag;
        r_busy   <= 1'b0;
      end
    end
  end

  assign mac_busy   = r_busy;
  assign mac_return = r_return;
  assign mac_ovf    = r_ovf;

endmodule

// File: tb/tb_mac_responder.sv
// ----------------------------------------------------------------------------
// tb_mac_responder
// Directed self-checking bench for mac_responder (WIDTH = 32). Inputs are
// driven on the falling edge or just after a rising edge; outputs are sampled
// on the falling edge. Define MAC_SATURATE_EN for both bench and RTL to
// check the clamping build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_responder;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] mac_num;
  logic [W-1:0] mac_y;
  logic         mac_req;
  logic         mac_busy;
  logic [W-1:0] mac_return;
  logic         mac_ovf;

  int n_checks = 0;
  int n_errors = 0;

  mac_responder #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mac_num    (mac_num),
    .mac_y      (mac_y),
    .mac_req    (mac_req),
    .mac_busy   (mac_busy),
    .mac_return (mac_return),
    .mac_ovf    (mac_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present arguments with a request at a falling edge; it is accepted on
  // the next rising edge. The request drops 1 ns after that edge.
  task automatic start_call(input logic [W-1:0] num, input logic [W-1:0] y);
    @(negedge clk);
    mac_num = num;
    mac_y   = y;
    mac_req = 1'b1;
    @(posedge clk);
    #1 mac_req = 1'b0;
  endtask

  // Count falling edges with busy high until busy is seen low; -1 on timeout.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mac_busy) return;
      n++;
    end
    n = -1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    mac_req = 1'b0;
    mac_num = '0;
    mac_y   = '0;
    #2;
    n_checks++;
    if ({mac_busy, mac_ovf, mac_return} !== {1'b0, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b ovf=%b ret=%h, want 0 0 0",
               mac_busy, mac_ovf, mac_return);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    start_call(32'd3, 32'd5);
    count_busy(n);
    n_checks++;
    if (n !== 4) begin
      n_errors++; $display("FAIL basic_busy_cycles: got %0d want 4", n);
    end
    n_checks++;
    if (mac_return !== 32'd15) begin
      n_errors++; $display("FAIL basic_return: got %0d want 15", mac_return);
    end
    n_checks++;
    if (mac_ovf !== 1'b0) begin
      n_errors++; $display("FAIL basic_ovf: got %b want 0", mac_ovf);
    end
  endtask

  task automatic test_zero();
    int n;
    start_call(32'd0, 32'd7);
    count_busy(n);
    n_checks++;
    if (n !== 1) begin
      n_errors++; $display("FAIL zero_busy_cycles: got %0d want 1", n);
    end
    n_checks++;
    if (mac_return !== 32'd0) begin
      n_errors++; $display("FAIL zero_return: got %0d want 0", mac_return);
    end
  endtask

  task automatic test_ignore_mid_run();
    int  n;
    logic seen_busy;
    start_call(32'd4, 32'd2);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mac_busy) begin
        n = i;
        break;
      end
      if (i == 1) begin
        mac_num = 32'd9;
        mac_y   = 32'd9;
        mac_req = 1'b1;
      end
      if (i == 2) mac_req = 1'b0;
    end
    n_checks++;
    if (n !== 5) begin
      n_errors++; $display("FAIL midrun_busy_cycles: got %0d want 5", n);
    end
    n_checks++;
    if (mac_return !== 32'd8) begin
      n_errors++; $display("FAIL midrun_return: got %0d want 8", mac_return);
    end
    seen_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_busy |= mac_busy;
    end
    n_checks++;
    if (seen_busy !== 1'b0) begin
      n_errors++; $display("FAIL midrun_no_second_call: busy seen=%b want 0", seen_busy);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [W-1:0] exp_ret;
`ifdef MAC_SATURATE_EN
    exp_ret = 32'hFFFF_FFFF;
`else
    exp_ret = 32'hFFFF_FFFE;
`endif
    start_call(32'd2, 32'hFFFF_FFFF);
    count_busy(n);
    n_checks++;
    if (n !== 3) begin
      n_errors++; $display("FAIL ovf_busy_cycles: got %0d want 3", n);
    end
    n_checks++;
    if (mac_return !== exp_ret) begin
      n_errors++; $display("FAIL ovf_return: got %h want %h", mac_return, exp_ret);
    end
    n_checks++;
    if (mac_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_flag: got %b want 1", mac_ovf);
    end
  endtask

  task automatic test_async_reset();
    int n;
    start_call(32'd10, 32'd3);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mac_busy, mac_return, mac_ovf} !== {1'b0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset_clear: busy=%b ret=%h ovf=%b, want 0 0 0",
               mac_busy, mac_return, mac_ovf);
    end
    @(negedge clk);
    reset   = 1'b1;
    mac_num = 32'd2;
    mac_y   = 32'd3;
    mac_req = 1'b1;
    @(posedge clk);
    #1 mac_req = 1'b0;
    count_busy(n);
    n_checks++;
    if (n !== 3) begin
      n_errors++; $display("FAIL post_reset_busy_cycles: got %0d want 3", n);
    end
    n_checks++;
    if (mac_return !== 32'd6) begin
      n_errors++; $display("FAIL post_reset_return: got %0d want 6", mac_return);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_busy [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    @(negedge clk);
    mac_num = 32'd1;
    mac_y   = 32'd4;
    mac_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (mac_busy !== exp_busy[i]) begin
        n_errors++;
        $display("FAIL b2b_busy[%0d]: got %b want %b", i, mac_busy, exp_busy[i]);
      end
      if (!exp_busy[i]) begin
        n_checks++;
        if (mac_return !== 32'd4) begin
          n_errors++;
          $display("FAIL b2b_return[%0d]: got %0d want 4", i, mac_return);
        end
      end
    end
    mac_req = 1'b0;
    count_busy(n);
    n_checks++;
    if (n < 0) begin
      n_errors++; $display("FAIL b2b_drain: busy never fell, got %0d want >=0", n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ignore_mid_run();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
